// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states, ALU ops, Op and Cond codes.
// The MC_CMP_EN build option (see mc_controller) uses CMD_CMP from here.
package mc_controller_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned FLAGS_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/mc_controller_if.sv
// Instruction fields in, datapath strobes and selects out; slave is the controller side.
interface mc_controller_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;

    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;

    modport master (
        output Op, Funct, Rd, Cond, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
        input  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        input  Op, Funct, Rd, Cond, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
        output ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

endinterface

// File: rtl/mc_condlogic.sv
// NZCV flags register plus combinational ARM condition evaluation against it.
module mc_condlogic
    import mc_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         cond_i,
    input  logic [FLAGS_W-1:0] alu_flags_i,
    input  logic [1:0]         flag_w_i,     // [1]: N,Z   [0]: C,V
    output logic               cond_ex_o
);

    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

    // Flags only change for an instruction whose own condition passed.
    always_comb begin
        flags_d = flags_q;
        if (flag_w_i[1] && cond_ex_o) flags_d[3:2] = alu_flags_i[3:2];
        if (flag_w_i[0] && cond_ex_o) flags_d[1:0] = alu_flags_i[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: main FSM, ALU/immediate decode, conditional write gating.
// Build option MC_CMP_EN: cmd=1010 with S=1 runs as CMP (sub, flags only, no writeback).
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mc_controller_if.slave bus
);

    state_t     state_q, state_d;
    logic [3:0] cmd;
    logic       s_bit;
    logic       is_cmp;
    logic       is_exec;
    logic [1:0] alu_op;
    logic [1:0] flag_w;
    logic       cond_ex;
    logic       rd_is_pc;

    logic       pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
    logic [1:0] result_src, alu_src_b, alu_control;

    assign cmd      = bus.Funct[4:1];
    assign s_bit    = bus.Funct[0];
    assign rd_is_pc = (bus.Rd == 4'hF);
    assign is_exec  = (state_q == S_EXECR) || (state_q == S_EXECI);

`ifdef MC_CMP_EN
    assign is_cmp = (cmd == CMD_CMP) && s_bit;
`else
    assign is_cmp = 1'b0;
`endif

    always_comb begin
        alu_op = ALU_ADD;
        case (cmd)
            CMD_ADD: alu_op = ALU_ADD;
            CMD_SUB: alu_op = ALU_SUB;
            CMD_AND: alu_op = ALU_AND;
            CMD_ORR: alu_op = ALU_ORR;
            default: alu_op = ALU_ADD;
        endcase
        if (is_cmp) alu_op = ALU_SUB;
    end

    // Logical ops leave C and V alone; only arithmetic ops may rewrite them.
    assign flag_w[1] = is_exec && s_bit;
    assign flag_w[0] = is_exec && s_bit && ((alu_op == ALU_ADD) || (alu_op == ALU_SUB));

    mc_condlogic u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (bus.Cond),
        .alu_flags_i (bus.ALUFlags),
        .flag_w_i    (flag_w),
        .cond_ex_o   (cond_ex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: state_d = s_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore outputs; write strobes are held low while reset is asserted.
    always_comb begin
        pc_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        result_src  = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: alu_src_b = 2'b01;
            S_MEMRD:  adr_src = 1'b1;
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex;
                pc_write   = cond_ex && rd_is_pc;
            end
            S_EXECR:  alu_control = alu_op;
            S_EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = alu_op;
            end
            S_ALUWB: begin
                reg_write = cond_ex && !is_cmp;
                pc_write  = cond_ex && !is_cmp && rd_is_pc;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.MemWrite   = mem_write;
    assign bus.RegWrite   = reg_write;
    assign bus.IRWrite    = ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;

    // Immediate and register-source selects follow Op directly, regardless of state.
    always_comb begin
        case (bus.Op)
            OP_MEM:  bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.RegSrc = {bus.Op == OP_MEM, bus.Op == OP_BR};

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios then random instructions against a per-instruction model.
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] m_flags;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] vec(input logic pcw, input logic memw, input logic regw,
                                        input logic irw, input logic adr, input logic srca,
                                        input logic [1:0] rs, input logic [1:0] sb,
                                        input logic [1:0] imm, input logic [1:0] rsrc,
                                        input logic [1:0] ac);
        return {pcw, memw, regw, irw, adr, srca, rs, sb, imm, rsrc, ac};
    endfunction

    function automatic logic [15:0] observed();
        return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA,
                bus.ResultSrc, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.ALUControl};
    endfunction

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting in FETCH; builds the expected per-cycle outputs from the ISA rules.
    task automatic do_instr(input string tag, input logic [1:0] op, input logic [5:0] funct,
                            input logic [3:0] rd, input logic [3:0] cond, input logic [3:0] aluf);
        logic [15:0] exp_q[$];
        logic [1:0]  imm, rsrc, ac;
        logic [3:0]  cmd;
        logic        s, c1, c2, cmp, pc15;
        cmd  = funct[4:1];
        s    = funct[0];
        pc15 = (rd == 4'hF);
        imm  = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        rsrc = {op == 2'b01, op == 2'b10};
`ifdef MC_CMP_EN
        cmp = (cmd == 4'b1010) && s;
`else
        cmp = 1'b0;
`endif
        bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.Cond = cond; bus.ALUFlags = aluf;
        exp_q.push_back(vec(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, imm, rsrc, 2'b00));
        exp_q.push_back(vec(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, imm, rsrc, 2'b00));
        c1 = cond_ok(cond, m_flags);
        case (op)
            2'b01: begin
                exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, imm, rsrc, 2'b00));
                if (s) begin
                    exp_q.push_back(vec(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, imm, rsrc, 2'b00));
                    exp_q.push_back(vec(c1 && pc15, 0, c1, 0, 0, 0, 2'b01, 2'b00, imm, rsrc, 2'b00));
                end else begin
                    exp_q.push_back(vec(0, c1, 0, 0, 1, 0, 2'b00, 2'b00, imm, rsrc, 2'b00));
                end
            end
            2'b00: begin
                if      (cmp)            ac = 2'b01;
                else if (cmd == 4'b0100) ac = 2'b00;
                else if (cmd == 4'b0010) ac = 2'b01;
                else if (cmd == 4'b0000) ac = 2'b10;
                else if (cmd == 4'b1100) ac = 2'b11;
                else                     ac = 2'b00;
                exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 2'b00, funct[5] ? 2'b01 : 2'b00, imm, rsrc, ac));
                if (s && c1) begin
                    m_flags[3:2] = aluf[3:2];
                    if (cmd != 4'b0000 && cmd != 4'b1100) m_flags[1:0] = aluf[1:0];
                end
                c2 = cond_ok(cond, m_flags) && !cmp;
                exp_q.push_back(vec(c2 && pc15, 0, c2, 0, 0, 0, 2'b00, 2'b00, imm, rsrc, 2'b00));
            end
            2'b10: exp_q.push_back(vec(c1, 0, 0, 0, 0, 0, 2'b10, 2'b01, imm, rsrc, 2'b00));
            default: exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, imm, rsrc, 2'b00));
        endcase
        #1;
        foreach (exp_q[i]) begin
            check16($sformatf("%s cyc%0d", tag, i + 1), observed(), exp_q[i]);
            @(posedge clk); #2;
        end
        check16($sformatf("%s flags", tag), 16'(dut.u_cond.flags_q), 16'(m_flags));
    endtask

    initial begin
        reset = 1'b1;
        m_flags = 4'b0000;
        bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd3; bus.Cond = 4'b1110; bus.ALUFlags = 4'b0000;
        #22 reset = 1'b0;
        #1;
        check16("reset state", 16'(dut.state_q), 16'(S_FETCH));
        check16("reset flags", 16'(dut.u_cond.flags_q), 16'h0000);
        check16("reset irw/pcw", {14'd0, bus.IRWrite, bus.PCWrite}, 16'h0003);
        #0;
        bus.Op = 2'b01; // inputs unchanged; do_instr re-applies them
        do_instr("ldr", 2'b01, 6'b011001, 4'd3, 4'b1110, 4'b0000);
        do_instr("str", 2'b01, 6'b011000, 4'd3, 4'b1110, 4'b0000);
        do_instr("subs z1", 2'b00, 6'b000101, 4'd2, 4'b1110, 4'b0100);
        do_instr("addeq taken", 2'b00, 6'b001000, 4'd2, 4'b0000, 4'b0000);
        do_instr("subs z0", 2'b00, 6'b000101, 4'd2, 4'b1110, 4'b0010);
        do_instr("addeq skip", 2'b00, 6'b001000, 4'd2, 4'b0000, 4'b1111);
        do_instr("ands", 2'b00, 6'b100001, 4'd4, 4'b1110, 4'b1011);
        do_instr("add pc", 2'b00, 6'b101000, 4'hF, 4'b1110, 4'b0000);
        do_instr("ldr pc", 2'b01, 6'b011001, 4'hF, 4'b1110, 4'b0000);
        do_instr("branch", 2'b10, 6'b000000, 4'd0, 4'b1110, 4'b0000);
        do_instr("branch nv", 2'b10, 6'b000000, 4'd0, 4'b1111, 4'b0000);
        do_instr("str nv", 2'b01, 6'b011000, 4'd1, 4'b1111, 4'b0000);
        do_instr("unknown", 2'b11, 6'b111111, 4'hF, 4'b1110, 4'b1111);
        do_instr("cmp eq", 2'b00, 6'b010101, 4'd5, 4'b1110, 4'b0110);

        // Abort an LDR in MEMRD with reset
        bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd6; bus.Cond = 4'b1110; bus.ALUFlags = 4'b0000;
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check16("abort state", 16'(dut.state_q), 16'(S_FETCH));
        check16("abort strobes", {14'd0, bus.MemWrite, bus.RegWrite}, 16'h0000);
        @(posedge clk); #2;
        check16("abort hold", {14'd0, bus.MemWrite, bus.RegWrite}, 16'h0000);
        reset = 1'b0;
        m_flags = 4'b0000;
        #1;
        check16("abort flags", 16'(dut.u_cond.flags_q), 16'h0000);
        do_instr("post abort", 2'b00, 6'b000101, 4'd1, 4'b1110, 4'b1000);

        for (int k = 0; k < 60; k++) begin
            do_instr($sformatf("rand%0d", k), 2'($urandom_range(0, 3)), 6'($urandom),
                     4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have no parameters; all encodings are fixed constants.
REQ-002 SHALL provide: clk  input  1  single clock, rising-edge.
REQ-003 SHALL provide: reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 SHALL provide: Op  input  2  instr[27:26]; 00 data-processing, 01 memory, 10 branch.
REQ-005 SHALL provide: Funct  input  6  instr[25:20]; I, cmd[3:0], S or L bit.
REQ-006 SHALL provide: Rd  input  4  instr[15:12].
REQ-007 SHALL provide: Cond  input  4  instr[31:28].
REQ-008 SHALL provide: ALUFlags  input  4  {N,Z,C,V} from the datapath ALU.
REQ-009 SHALL provide: PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA  output  1 each  datapath strobes and mux selects.
REQ-010 SHALL provide: ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl  output  2 each  datapath selects.

Function
REQ-011 SHALL sequence a multicycle datapath with these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNKNOWN.
REQ-012 SHALL use these transitions: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECI (Op=00, Funct[5]=1), EXECR (Op=00, Funct[5]=0), BRANCH (Op=10), UNKNOWN (otherwise).
REQ-013 SHALL use these further transitions: MEMADR->MEMRD (Funct[0]=1) or MEMWR (Funct[0]=0); MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH; UNKNOWN->FETCH.
REQ-014 In FETCH, SHALL drive IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00 (add), ResultSrc=10, and PCWrite=1 unconditionally.
REQ-015 In DECODE, SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 toward R15) and no write strobes.
REQ-016 In MEMADR, SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=00.
REQ-017 In MEMRD and MEMWR, SHALL drive ResultSrc=00 and AdrSrc=1.
REQ-018 In MEMWB, SHALL drive ResultSrc=01.
REQ-019 In EXECR, SHALL drive ALUSrcB=00; in EXECI, ALUSrcB=01.
REQ-020 In EXECR/EXECI, SHALL drive ALUControl from cmd: 0100->00 add, 0010->01 sub, 0000->10 and, 1100->11 orr, any other->00.
REQ-021 In ALUWB, SHALL drive ResultSrc=00.
REQ-022 In BRANCH, SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, and a branch-PC request.
REQ-023 SHALL decode ImmSrc combinationally from Op (00->00, 01->01, 10->10) and RegSrc as {Op==01, Op==10}, independent of state.
REQ-024 SHALL hold a 4-bit flags register {N,Z,C,V}.
REQ-025 SHALL load the flags register from ALUFlags at the end of EXECR/EXECI only when Funct[0]=1 and CondEx=1.
REQ-026 SHALL update N,Z for all flag-setting ops and C,V only for add/sub.
REQ-027 SHALL compute CondEx combinationally from Cond and the flags register for the 15 ARM conditions EQ..AL; Cond=1111 SHALL give CondEx=0.
REQ-028 SHALL gate RegWrite (MEMWB, ALUWB), MemWrite (MEMWR) and the BRANCH PC write with CondEx.
REQ-029 SHALL force PCWrite on ALUWB/MEMWB when Rd=1111 and CondEx=1.
REQ-030 SHALL drive all write strobes to 0 in UNKNOWN.
REQ-031 Each instruction SHALL take: LDR 5 cycles, STR 4, data-processing 4, branch 3, unknown 3.

Reset
REQ-032 While reset=1, SHALL hold state FETCH and clear the flags register to 0000.
REQ-033 Asserting reset mid-instruction SHALL abort the instruction with no further write strobes.
REQ-034 After reset deasserts, the first rising edge SHALL execute FETCH.

Configuration
REQ-035 When MC_CMP_EN is defined, cmd=1010 with S=1 SHALL execute as sub, update flags, and suppress RegWrite in ALUWB.
REQ-036 When MC_CMP_EN is undefined, cmd=1010 SHALL execute as ALUControl=00 with RegWrite permitted.

Structure
REQ-037 A shared package SHALL hold the state enum, the ALUControl codes, the Op codes, and the Cond codes.
REQ-038 Condition evaluation and the flags register SHALL be one sub-module, mc_condlogic; the FSM and decode SHALL remain in mc_controller.

Verification
REQ-039 Reset: assert reset at t=0, release at 22 ns -> state=FETCH, flags=0000, IRWrite=1 and PCWrite=1 in the first cycle.
REQ-040 LDR: Op=01, Funct=011001, Cond=1110 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 only in cycle 5.
REQ-041 STR: Op=01, Funct=011000, Cond=1110 -> MemWrite=1 only in cycle 4 (MEMWR); RegWrite is never 1.
REQ-042 Conditional: SUBS giving Z=1, then ADDEQ -> RegWrite=1 in ALUWB; with Z=0 instead -> RegWrite=0 and flags unchanged.
REQ-043 Branch: Op=10, Cond=1110 -> 3 cycles with branch-PC write in BRANCH; Op=11 -> UNKNOWN with no writes, then FETCH.
REQ-044 Abort and CMP: reset asserted during MEMRD -> MemWrite and RegWrite stay 0 and state=FETCH; with MC_CMP_EN defined, CMP of equal operands -> Z=1 and RegWrite=0.
